// File: rtl/i_cache_pkg.sv
// Shared geometry, address-field widths and FSM state type for the instruction cache.
package i_cache_pkg;

  localparam int WORD_SIZE   = 16;
  localparam int LINE_WORDS  = 4;
  localparam int NUM_LINES   = 8;
  localparam int MEM_LATENCY = 3;
  localparam int CNT_W       = 16;

  localparam int OFFSET_W = $clog2(LINE_WORDS);
  localparam int INDEX_W  = $clog2(NUM_LINES);
  localparam int TAG_W    = WORD_SIZE - OFFSET_W - INDEX_W;
  localparam int LAT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic {
    IDLE,
    FILL
  } state_t;

  function automatic logic [WORD_SIZE-1:0] line_base(input logic [TAG_W-1:0] tag,
                                                     input logic [INDEX_W-1:0] idx);
    return {tag, idx, {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/i_cache_if.sv
// Fetch-side and memory-side signals of the instruction cache; slave is the cache itself.
interface i_cache_if;
  import i_cache_pkg::*;

  logic                 cpu_read;
  logic [WORD_SIZE-1:0] cpu_address;
  logic [WORD_SIZE-1:0] cpu_data;
  logic                 cpu_ready;
  logic                 flush;
  logic                 i_readM;
  logic                 i_writeM;
  logic [WORD_SIZE-1:0] i_address;
  logic [WORD_SIZE-1:0] i_data;

  modport master (
    output cpu_read, cpu_address, flush, i_data,
    input  cpu_data, cpu_ready, i_readM, i_writeM, i_address
  );

  modport slave (
    input  cpu_read, cpu_address, flush, i_data,
    output cpu_data, cpu_ready, i_readM, i_writeM, i_address
  );

endinterface

// File: rtl/i_cache_sat_counter.sv
// Saturating up-counter used for the hit and miss performance counters.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/i_cache.sv
// Direct-mapped read-only instruction cache: same-cycle hits, in-order line fill on a miss.
module i_cache
  import i_cache_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  i_cache_if.slave         bus,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  state_t                state;
  logic [NUM_LINES-1:0]  valid;
  logic [TAG_W-1:0]      tag_mem  [NUM_LINES];
  logic [WORD_SIZE-1:0]  data_mem [NUM_LINES][LINE_WORDS];

  logic [TAG_W-1:0]      line_tag;
  logic [INDEX_W-1:0]    line_idx;
  logic [OFFSET_W-1:0]   word_ctr;
  logic [LAT_W-1:0]      lat_ctr;
  logic                  just_filled;

  logic [TAG_W-1:0]      req_tag;
  logic [INDEX_W-1:0]    req_idx;
  logic [OFFSET_W-1:0]   req_off;
  logic [OFFSET_W-1:0]   next_word;
  logic                  lookup_hit;
  logic                  serve;
  logic                  hit;
  logic                  miss;
  logic                  lat_done;
  logic                  last_word;
  logic                  hit_inc;

  assign req_tag   = bus.cpu_address[WORD_SIZE-1 -: TAG_W];
  assign req_idx   = bus.cpu_address[OFFSET_W +: INDEX_W];
  assign req_off   = bus.cpu_address[OFFSET_W-1:0];
  assign next_word = word_ctr + OFFSET_W'(1);

  assign lookup_hit = valid[req_idx] && (tag_mem[req_idx] == req_tag);
  assign serve      = (state == IDLE) && bus.cpu_read && !bus.flush;
  assign hit        = serve && lookup_hit;
  assign miss       = serve && !lookup_hit;
  assign lat_done   = (lat_ctr == LAT_W'(MEM_LATENCY - 1));
  assign last_word  = (word_ctr == OFFSET_W'(LINE_WORDS - 1));

  assign bus.cpu_ready = hit;
  assign bus.cpu_data  = hit ? data_mem[req_idx][req_off] : '0;
  assign bus.i_writeM  = 1'b0;

  // The serving cycle right after a fill belongs to a request already counted as a miss.
  assign hit_inc = hit && !just_filled;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      valid         <= '0;
      bus.i_readM   <= 1'b0;
      bus.i_address <= '0;
      line_tag      <= '0;
      line_idx      <= '0;
      word_ctr      <= '0;
      lat_ctr       <= '0;
      just_filled   <= 1'b0;
    end else begin
      just_filled <= 1'b0;
      if (bus.flush) begin
        valid       <= '0;
        state       <= IDLE;
        bus.i_readM <= 1'b0;
        word_ctr    <= '0;
        lat_ctr     <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (miss) begin
              line_tag      <= req_tag;
              line_idx      <= req_idx;
              bus.i_address <= line_base(req_tag, req_idx);
              bus.i_readM   <= 1'b1;
              word_ctr      <= '0;
              lat_ctr       <= '0;
              state         <= FILL;
            end
          end
          FILL: begin
            if (lat_done) begin
              lat_ctr <= '0;
              if (last_word) begin
                valid[line_idx] <= 1'b1;
                bus.i_readM     <= 1'b0;
                word_ctr        <= '0;
                just_filled     <= 1'b1;
                state           <= IDLE;
              end else begin
                word_ctr      <= next_word;
                bus.i_address <= {line_tag, line_idx, next_word};
              end
            end else begin
              lat_ctr <= lat_ctr + LAT_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Storage arrays carry no reset; the valid bits alone qualify their contents.
  always_ff @(posedge clk) begin
    if ((state == FILL) && lat_done && !bus.flush) begin
      data_mem[line_idx][word_ctr] <= bus.i_data;
      if (last_word) begin
        tag_mem[line_idx] <= line_tag;
      end
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst_n (reset_n),
    .inc   (hit_inc),
    .count (hit_count)
  );

  sat_counter #(.WIDTH(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst_n (reset_n),
    .inc   (miss),
    .count (miss_count)
  );

endmodule

// File: tb/tb_i_cache.sv
// Self-checking bench for i_cache: vector table through a scoreboard, plus flush/reset/saturation sequences.
module tb_i_cache;

  localparam int MEM_LAT  = 3;
  localparam int MISS_LAT = 4 * MEM_LAT + 1;
  localparam int MAX_CYC  = 40;
  localparam int NVEC     = 14;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    int          lat;
    logic [15:0] hits;
    logic [15:0] misses;
  } vec_t;

  logic        clk;
  logic        reset_n;
  logic [15:0] hit_count;
  logic [15:0] miss_count;
  logic [15:0] mem [0:65535];

  int n_checks;
  int n_errors;

  vec_t vecs [NVEC];
  vec_t sb [$];

  i_cache_if bus ();

  i_cache dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus.slave),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.i_data = mem[bus.i_address];

  function automatic logic [15:0] mem_val(input logic [15:0] a);
    case (a)
      16'h0020, 16'h0021, 16'h0022: return 16'h0000;
      16'h0023:                     return 16'h6000;
      16'h0043:                     return 16'hF1C2;
      default:                      return 16'(a * 16'h9E37) ^ 16'h5A5A;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Presents a fetch at posedge+1 and returns at posedge+1 after counters are checked.
  task automatic fetch(input logic [15:0] addr, input logic [15:0] exp_data, input int exp_lat,
                       input logic [15:0] exp_hits, input logic [15:0] exp_misses);
    vec_t        e;
    int          cyc;
    bit          got;
    bit          trace_ok;
    logic [15:0] base;
    logic [15:0] want;
    sb.push_back('{addr, exp_data, exp_lat, exp_hits, exp_misses});
    bus.cpu_address = addr;
    bus.cpu_read    = 1'b1;
    cyc      = 0;
    got      = 1'b0;
    trace_ok = 1'b1;
    base     = {addr[15:2], 2'b00};
    while (!got && cyc < MAX_CYC) begin
      @(negedge clk);
      if (bus.cpu_ready === 1'b1) begin
        got = 1'b1;
      end else begin
        if (cyc == 0) begin
          if (bus.i_readM !== 1'b0) trace_ok = 1'b0;
        end else begin
          want = base + 16'((cyc - 1) / MEM_LAT);
          if (bus.i_readM !== 1'b1 || bus.i_address !== want) trace_ok = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    e = sb.pop_front();
    if (!got) begin
      check($sformatf("ready_timeout@%h", e.addr), 32'(got), 32'd1);
    end else begin
      check($sformatf("data@%h", e.addr), 32'(bus.cpu_data), 32'(e.data));
      check($sformatf("latency@%h", e.addr), 32'(cyc), 32'(e.lat));
      check($sformatf("readM_on_ready@%h", e.addr), 32'(bus.i_readM), 32'd0);
      if (e.lat > 0) check($sformatf("fill_trace@%h", e.addr), 32'(trace_ok), 32'd1);
    end
    @(posedge clk);
    #1;
    bus.cpu_read = 1'b0;
    @(negedge clk);
    check($sformatf("hit_count@%h", e.addr), 32'(hit_count), 32'(e.hits));
    check($sformatf("miss_count@%h", e.addr), 32'(miss_count), 32'(e.misses));
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 65536; i++) mem[i] = mem_val(16'(i));

    vecs[0]  = '{16'h0023, 16'h6000,          MISS_LAT, 16'd0, 16'd1};
    vecs[1]  = '{16'h0021, 16'h0000,          0,        16'd1, 16'd1};
    vecs[2]  = '{16'h0043, 16'hF1C2,          MISS_LAT, 16'd1, 16'd2};
    vecs[3]  = '{16'h0023, 16'h6000,          MISS_LAT, 16'd1, 16'd3};
    vecs[4]  = '{16'h0044, mem_val(16'h0044), MISS_LAT, 16'd1, 16'd4};
    vecs[5]  = '{16'h0045, mem_val(16'h0045), 0,        16'd2, 16'd4};
    vecs[6]  = '{16'h0123, mem_val(16'h0123), MISS_LAT, 16'd2, 16'd5};
    vecs[7]  = '{16'h0120, mem_val(16'h0120), 0,        16'd3, 16'd5};
    vecs[8]  = '{16'h00FF, mem_val(16'h00FF), MISS_LAT, 16'd3, 16'd6};
    vecs[9]  = '{16'h00FC, mem_val(16'h00FC), 0,        16'd4, 16'd6};
    vecs[10] = '{16'h0022, 16'h0000,          MISS_LAT, 16'd4, 16'd7};
    vecs[11] = '{16'h0047, mem_val(16'h0047), 0,        16'd5, 16'd7};
    vecs[12] = '{16'hFFFF, mem_val(16'hFFFF), MISS_LAT, 16'd5, 16'd8};
    vecs[13] = '{16'hFFFC, mem_val(16'hFFFC), 0,        16'd6, 16'd8};

    reset_n         = 1'b0;
    bus.cpu_read    = 1'b0;
    bus.cpu_address = '0;
    bus.flush       = 1'b0;
    #13;
    check("rst_cpu_ready", 32'(bus.cpu_ready), 32'd0);
    check("rst_cpu_data", 32'(bus.cpu_data), 32'd0);
    check("rst_i_readM", 32'(bus.i_readM), 32'd0);
    check("rst_i_address", 32'(bus.i_address), 32'd0);
    check("rst_i_writeM", 32'(bus.i_writeM), 32'd0);
    check("rst_hit_count", 32'(hit_count), 32'd0);
    check("rst_miss_count", 32'(miss_count), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int v = 0; v < NVEC; v++) begin
      fetch(vecs[v].addr, vecs[v].data, vecs[v].lat, vecs[v].hits, vecs[v].misses);
    end

    // Flush in IDLE drops the cached line.
    fetch(16'h0023, 16'h6000, 0, 16'd7, 16'd8);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    fetch(16'h0023, 16'h6000, MISS_LAT, 16'd7, 16'd9);

    // Flush during word 2 of a fill.
    bus.cpu_address = 16'h0043;
    bus.cpu_read    = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    check("flush_fill_addr", 32'(bus.i_address), 32'h42);
    check("flush_fill_readM", 32'(bus.i_readM), 32'd1);
    bus.flush = 1'b1;
    @(negedge clk);
    check("flush_cycle_ready", 32'(bus.cpu_ready), 32'd0);
    @(posedge clk);
    #1;
    bus.flush    = 1'b0;
    bus.cpu_read = 1'b0;
    @(negedge clk);
    check("flush_abort_readM", 32'(bus.i_readM), 32'd0);
    check("flush_abort_miss", 32'(miss_count), 32'd10);
    check("flush_abort_hit", 32'(hit_count), 32'd7);
    @(posedge clk);
    #1;
    fetch(16'h0043, 16'hF1C2, MISS_LAT, 16'd7, 16'd11);

    // Reset during word 2 of a fill.
    bus.cpu_address = 16'h0023;
    bus.cpu_read    = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    check("reset_fill_addr", 32'(bus.i_address), 32'h22);
    reset_n      = 1'b0;
    bus.cpu_read = 1'b0;
    #1;
    check("reset_abort_readM", 32'(bus.i_readM), 32'd0);
    check("reset_abort_hit", 32'(hit_count), 32'd0);
    check("reset_abort_miss", 32'(miss_count), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    fetch(16'h0023, 16'h6000, MISS_LAT, 16'd0, 16'd1);

    // Flush wins over a same-cycle hit.
    bus.cpu_address = 16'h0021;
    bus.cpu_read    = 1'b1;
    bus.flush       = 1'b1;
    @(negedge clk);
    check("flush_prio_ready", 32'(bus.cpu_ready), 32'd0);
    @(posedge clk);
    #1;
    bus.flush    = 1'b0;
    bus.cpu_read = 1'b0;
    @(negedge clk);
    check("flush_prio_hit", 32'(hit_count), 32'd0);
    check("flush_prio_miss", 32'(miss_count), 32'd1);
    @(posedge clk);
    #1;
    fetch(16'h0021, 16'h0000, MISS_LAT, 16'd0, 16'd2);

    // Held request hits every cycle until the hit counter saturates.
    bus.cpu_address = 16'h0021;
    bus.cpu_read    = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    check("hit_near_sat", 32'(hit_count), 32'hFFFE);
    @(posedge clk);
    #1;
    check("hit_at_sat", 32'(hit_count), 32'hFFFF);
    repeat (4) @(posedge clk);
    #1;
    check("hit_held_sat", 32'(hit_count), 32'hFFFF);
    check("miss_after_sat", 32'(miss_count), 32'd2);
    bus.cpu_read = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/i_cache.md
# i_cache

Direct-mapped, read-only instruction cache between the CPU fetch stage and the instruction port of the unified memory. A hit returns the instruction word in the same cycle. A miss stalls the CPU while the cache fills the whole line from memory, one word at a time, over the fixed-latency i_readM / i_address / i_data interface. The block also keeps saturating hit and miss counters for performance measurement.

## Interface
- WORD_SIZE, 16, data and address width
- LINE_WORDS, 4, words per line (power of two)
- NUM_LINES, 8, number of lines (power of two)
- MEM_LATENCY, 3, cycles that i_readM and i_address must be held per memory word
- clk  input  1  system clock, rising-edge active
- reset_n  input  1  asynchronous, active-low reset
- cpu_read  input  1  fetch request; held high with a stable cpu_address until cpu_ready
- cpu_address  input  WORD_SIZE  word address of the fetch
- cpu_data  output  WORD_SIZE  instruction word; valid while cpu_ready is high
- cpu_ready  output  1  request served this cycle
- flush  input  1  invalidate all lines
- i_readM  output  1  memory read request
- i_writeM  output  1  tied 0
- i_address  output  WORD_SIZE  memory word address
- i_data  input  WORD_SIZE  memory read data
- hit_count  output  16  saturating hit counter
- miss_count  output  16  saturating miss counter

## Operation
- Address split: offset = addr[1:0], index = addr[4:2], tag = addr[15:5]. These widths derive from the parameters.
- Storage per line: valid bit, tag, and LINE_WORDS data words.
- FSM states are IDLE and FILL.
- IDLE, cpu_read high, line valid and tags equal (hit):
  - cpu_ready = 1 combinationally.
  - cpu_data = the addressed word.
  - hit_count increments at the clock edge.
- IDLE, cpu_read high, miss:
  - cpu_ready = 0.
  - miss_count increments.
  - Latch the line base address {tag, index, 2'b00}.
  - word_ctr = 0, lat_ctr = 0.
  - Go to FILL.
- FILL:
  - i_readM = 1; i_address = base + word_ctr.
  - lat_ctr counts 0..MEM_LATENCY-1. On the edge where lat_ctr == MEM_LATENCY-1, write i_data into data[index][word_ctr], clear lat_ctr, and increment word_ctr.
  - After the last word is written: set valid and tag at the same edge, then return to IDLE.
  - The held request then hits on the next cycle.
- Fill order is ascending from offset 0. There is no critical-word-first and no early restart.
- The line being filled stays invalid until the last word is written. cpu_ready stays 0 throughout FILL.
- flush:
  - Clears all valid bits at the edge.
  - In FILL, it aborts the fill: i_readM drops next cycle and the FSM returns to IDLE.
  - A request still held afterwards misses again.
  - flush has priority over a hit or miss decision in the same cycle. That cycle returns cpu_ready = 0 and counts neither a hit nor a miss.
- cpu_read low in IDLE: no action, no counting.
- Counters saturate at 16'hFFFF.

## Timing
- Reset (asynchronous) sets:
  - all valid bits = 0
  - state = IDLE
  - i_readM = 0, i_address = 0
  - cpu_ready = 0, cpu_data = 0
  - hit_count = miss_count = 0
  - word_ctr = lat_ctr = 0
- Data arrays need no reset.
- Hit latency is 0 cycles: cpu_ready is high in the cycle the request is presented.
- Miss penalty is LINE_WORDS × MEM_LATENCY + 1 cycles: 13 cycles at the defaults, from the request cycle to the cpu_ready cycle.
- i_readM and i_address change only at rising edges. Each address is held exactly MEM_LATENCY cycles.
- A reset during FILL abandons the fill immediately and leaves no partially valid line.
- A change of cpu_address during FILL is a protocol violation. The cache finishes the latched line.

## Structure
- Shared package holds:
  - WORD_SIZE
  - the FSM state enum (IDLE, FILL)
  - address-field width localparams: OFFSET_W, INDEX_W, TAG_W, derived from LINE_WORDS and NUM_LINES
- Sub-module sat_counter (width parameter; inc input; asynchronous active-low reset) is instantiated twice, for hit_count and miss_count.

## Test plan
- Reset, then fetch 0x0023 with memory preloaded (0x20..0x23 = 0, 0, 0, 0x6000):
  - i_address steps 0x20, 0x21, 0x22, 0x23, each held 3 cycles.
  - cpu_ready goes high at cycle 13 with cpu_data = 0x6000.
  - miss_count = 1.
- Next fetch 0x0021 → cpu_ready high in the same cycle, cpu_data = 0x0000, hit_count = 1, i_readM stays 0.
- Conflict: fetch 0x0023, then 0x0043 (same index 0, different tag), then 0x0023:
  - all three miss, miss_count = 3;
  - the second fetch returns 0xF1C2.
- flush asserted in IDLE after 0x0023 is cached → the next 0x0023 fetch misses and refills.
- flush or reset_n low during word 2 of a fill:
  - i_readM drops on the next cycle (flush) or immediately (reset);
  - the line is not valid;
  - the re-request misses.
- Preload hit_count near 0xFFFF (or issue 65 540 hits) → it holds at 0xFFFF.
